vga_scan_ctrl: RTL
==================

Name: vga_scan_ctrl

Overview:
- VGA 640x480@60 Hz scan generator and pixel output stage. It is the consumer end of the sprite colour-lookup interface.
- Drives the col/row scan coordinates into the sprite colour blocks and accepts their registered 16-bit colour back a fixed latency later.
- Delays sync and blanking to match that latency, then drives the board's 12-bit RGB and hs/vs pins.
- Also emits a frame-start pulse that game logic uses to update sprite positions and animation state.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SW, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SW, 2, vsync width
- V_BP, 33, vertical back porch
- PIPE_LAT, 1, clock cycles from col/row to valid color input; range 1..4

Ports:
- clk  in  1  25 MHz pixel clock; one pixel per cycle
- clrn  in  1  reset, synchronous, active-low
- color  in  16  RGB565 from the sprite/compositor path: [15:11] R, [10:5] G, [4:0] B
- col  out  10  current scan column, 0..639
- row  out  9  current scan row, 0..479
- rdn  out  1  active-low "col/row is a visible pixel"
- frame_start  out  1  one-cycle pulse at pixel (0,0)
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- r  out  4  red, color[15:12]
- g  out  4  green, color[10:7]
- b  out  4  blue, color[4:1]

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOT-1, where H_TOT = H_VIS+H_FP+H_SW+H_BP = 800. It wraps to 0.
  - v_cnt runs 0..V_TOT-1, where V_TOT = 525. It increments only when h_cnt wraps, and wraps to 0 when both counters are at their maxima.
- Region decode, from counter registers, combinational:
  - visible = h_cnt < H_VIS && v_cnt < V_VIS
  - hs_raw low for H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SW (656..751)
  - vs_raw low for 490 <= v_cnt < 492
- Coordinate outputs:
  - When visible: col = h_cnt[9:0], row = v_cnt[8:0], rdn = 0.
  - Otherwise: col = 0, row = 0, rdn = 1.
- frame_start = (h_cnt==0 && v_cnt==0) and not in reset.
- Alignment delay: a PIPE_LAT-stage shift register carries {visible, hs_raw, vs_raw}. Its tap, de_d/hs_d/vs_d, is aligned with the cycle in which color is valid for the coordinates issued PIPE_LAT cycles earlier.
- Output register, every clk:
  - hs <= hs_d; vs <= vs_d
  - {r,g,b} <= de_d ? {color[15:12], color[10:7], color[4:1]} : 12'h000
- Latency:
  - The pixel addressed by col/row in cycle n appears on r/g/b in cycle n+PIPE_LAT+1.
  - hs/vs have identical latency, so sync-to-pixel phase on the pins equals sync-to-pixel phase at the counters.
- Blanking is forced to 0 regardless of color; a colour block's 16'hffff "no sprite" value during blanking never reaches the pins.
- Reset (clrn low at a clk edge), including mid-frame:
  - h_cnt = v_cnt = 0; all delay stages cleared to visible=0, hs=1, vs=1.
  - Outputs: hs = vs = 1, r = g = b = 0, col = row = 0, rdn = 1, frame_start = 0 while clrn is low.
- Reset release:
  - First cycle with clrn high presents (0,0): rdn = 0, frame_start = 1.
  - First visible RGB appears PIPE_LAT+1 cycles later.
- Wrap corner: at h_cnt=799, v_cnt=524 the next cycle is (0,0) with frame_start; no extra or missing line.
- color is sampled only through the output register. It is ignored, not registered elsewhere, when de_d = 0.

Decomposition:
- Package vga_timing_pkg holds:
  - H_VIS, H_FP, H_SW, H_BP, V_VIS, V_FP, V_SW, V_BP
  - derived H_TOT, V_TOT, HS_START, HS_END, VS_START, VS_END
  - RGB565 field slice constants
- Sub-module sync_delay_line: width-3, depth-PIPE_LAT shift register with synchronous active-low clear to a parameterised reset pattern (3'b011 for {de,hs,vs}).

Test Plan:
- Reset held 10 cycles, then released -> during reset hs=vs=1, rgb=0, rdn=1. First released cycle: col=0, row=0, rdn=0, frame_start=1.
- Run one line with color=16'hF800 -> r=4'hF, g=0, b=0 for exactly 640 consecutive cycles starting PIPE_LAT+1 cycles after rdn first falls. hs low for exactly 96 cycles starting 656 cycles after the first red pixel's counter cycle.
- Run 2 full frames -> frame_start period exactly 420000 cycles; vs low for exactly 1600 cycles (2 lines) per frame; 480 lines with rdn=0 per frame.
- color held 16'hFFFF continuously -> r=g=b=4'hF only while the delayed visible flag is set; 0 in all 160 blank cycles of each line and in all 45 blank lines.
- Drive color = {col[4:0], row[5:0], col[9:5]} from a PIPE_LAT-cycle delayed model, with PIPE_LAT=1 and 3 -> each RGB output matches that function of the coordinates issued PIPE_LAT+1 cycles earlier, with no off-by-one at col 0 or 639.
- Assert clrn low at h_cnt=300, v_cnt=200 for 1 cycle -> the next cycle shows col=0, row=0, frame_start=1, and hs/vs/rgb return to their reset values through the delay pipeline.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz VGA timing, derived sync windows and RGB565 field positions.
// Shared by the scan generator and its sync delay line.
package vga_timing_pkg;

    localparam int unsigned H_VIS = 640;
    localparam int unsigned H_FP  = 16;
    localparam int unsigned H_SW  = 96;
    localparam int unsigned H_BP  = 48;
    localparam int unsigned V_VIS = 480;
    localparam int unsigned V_FP  = 10;
    localparam int unsigned V_SW  = 2;
    localparam int unsigned V_BP  = 33;

    localparam int unsigned H_TOT    = H_VIS + H_FP + H_SW + H_BP;
    localparam int unsigned V_TOT    = V_VIS + V_FP + V_SW + V_BP;
    localparam int unsigned HS_START = H_VIS + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SW;
    localparam int unsigned VS_START = V_VIS + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SW;

    // Top four bits of each RGB565 field drive the 4-bit DAC pins.
    localparam int unsigned R_MSB = 15;
    localparam int unsigned R_LSB = 12;
    localparam int unsigned G_MSB = 10;
    localparam int unsigned G_LSB = 7;
    localparam int unsigned B_MSB = 4;
    localparam int unsigned B_LSB = 1;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    // Blank, both syncs inactive (high).
    localparam logic [2:0] SYNC_IDLE = 3'b011;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that aligns sync/blank flags with the colour-lookup latency.
// Synchronous active-low clear loads every stage with RstVal.
module sync_delay_line #(
    parameter int unsigned     Width  = 3,
    parameter int unsigned     Depth  = 1,
    parameter logic [Width-1:0] RstVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] stage_q [Depth];
    logic [Width-1:0] stage_d [Depth];

    always_comb begin
        stage_d[0] = data_i;
        for (int i = 1; i < int'(Depth); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stage_q[i] <= RstVal;
            end
        end else begin
            for (int i = 0; i < int'(Depth); i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign data_o = stage_q[Depth-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan generator: issues col/row to the colour lookup, realigns sync/blank to its
// latency and registers the 12-bit RGB and hs/vs pins.
module vga_scan_ctrl #(
    parameter int unsigned H_VIS    = vga_timing_pkg::H_VIS,
    parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
    parameter int unsigned H_SW     = vga_timing_pkg::H_SW,
    parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
    parameter int unsigned V_VIS    = vga_timing_pkg::V_VIS,
    parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
    parameter int unsigned V_SW     = vga_timing_pkg::V_SW,
    parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
    parameter int unsigned PIPE_LAT = 1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [15:0] color,
    output logic [9:0]  col,
    output logic [8:0]  row,
    output logic        rdn,
    output logic        frame_start,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);

    import vga_timing_pkg::*;

    localparam int unsigned HTot    = H_VIS + H_FP + H_SW + H_BP;
    localparam int unsigned VTot    = V_VIS + V_FP + V_SW + V_BP;
    localparam int unsigned HsStart = H_VIS + H_FP;
    localparam int unsigned HsEnd   = HsStart + H_SW;
    localparam int unsigned VsStart = V_VIS + V_FP;
    localparam int unsigned VsEnd   = VsStart + V_SW;

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        h_last, v_last;
    logic        visible;
    sync_t       sync_raw, sync_tap;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [11:0] rgb_q, rgb_d;
    logic        unused_color_bits;

    always_comb begin
        h_last  = (h_cnt_q == 10'(HTot - 1));
        v_last  = (v_cnt_q == 10'(VTot - 1));
        h_cnt_d = h_last ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        visible     = (h_cnt_q < 10'(H_VIS)) && (v_cnt_q < 10'(V_VIS));
        sync_raw.de = visible;
        sync_raw.hs = !((h_cnt_q >= 10'(HsStart)) && (h_cnt_q < 10'(HsEnd)));
        sync_raw.vs = !((v_cnt_q >= 10'(VsStart)) && (v_cnt_q < 10'(VsEnd)));
    end

    // Gated by clrn so a held reset never looks like pixel (0,0) to the sprite blocks.
    assign col         = (visible && clrn) ? h_cnt_q : 10'd0;
    assign row         = (visible && clrn) ? v_cnt_q[8:0] : 9'd0;
    assign rdn         = !(visible && clrn);
    assign frame_start = clrn && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    sync_delay_line #(
        .Width  (3),
        .Depth  (PIPE_LAT),
        .RstVal (SYNC_IDLE)
    ) u_sync_dly (
        .clk_i  (clk),
        .rst_ni (clrn),
        .data_i (sync_raw),
        .data_o (sync_tap)
    );

    always_comb begin
        hs_d  = sync_tap.hs;
        vs_d  = sync_tap.vs;
        rgb_d = 12'h000;
        if (sync_tap.de) begin
            rgb_d = {color[R_MSB:R_LSB], color[G_MSB:G_LSB], color[B_MSB:B_LSB]};
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= 12'h000;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
        end
    end

    assign unused_color_bits = ^{color[11], color[5], color[0]};

    assign hs = hs_q;
    assign vs = vs_q;
    assign r  = rgb_q[11:8];
    assign g  = rgb_q[7:4];
    assign b  = rgb_q[3:0];

endmodule
